mux_sel_arbiter: RTL and testbench

Round-robin arbiter that shares the 8:1 `Mux` datapath between up to N requesters. It drives the mux `sel` input and grants one requester at a time. Each grant lasts a bounded burst of handshaked transfers. The block sits directly in front of `Mux`: its `sel` output connects straight to the mux select, and its `valid`/`ready` pair qualifies the mux output toward the downstream consumer.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/mux_sel_arbiter_rr_pick.sv | 29 ++
 rtl/mux_sel_arbiter.sv | 89 ++++++++
 tb/tb_mux_sel_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the mux select arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned N_REQ_DEF    = 8;
    localparam int unsigned MAX_HOLD_DEF = 4;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Rotating priority picker: first set bit of req at or above ptr, wrapping to 0.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = SEL_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the shared mux select with bounded per-grant bursts.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned SEL_W    = $clog2(N_REQ),
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             xfer;
    logic             last_xfer;
    logic             release_g;

    assign sel_inc   = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    assign valid     = (state == GRANT) && req[sel];
    assign xfer      = valid && ready;
    assign last_xfer = xfer && (cnt == CNT_W'(MAX_HOLD - 1));
    assign release_g = (state == GRANT) && (!req[sel] || last_xfer);

    // While granted the only pick that matters is the release re-pick, which
    // scans from the slot after the current owner rather than the stored ptr.
    assign pick_ptr  = (state == GRANT) ? sel_inc : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel   <= pick_idx;
                        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_g) begin
                        ptr <= sel_inc;
                        if (pick_found) begin
                            sel <= pick_idx;
                            gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            cnt <= '0;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter against a high-level round-robin model.
module tb_mux_sel_arbiter;

    localparam int N = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       ready = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .N_REQ    (8),
        .SEL_W    (3),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid)
    );

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: owner index (-1 when nobody holds the mux), transfers in this burst,
    // scan start position and the last select driven.
    int owner    = -1;
    int burst    = 0;
    int mptr     = 0;
    int last_sel = 0;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        burst    = 0;
        mptr     = 0;
        last_sel = 0;
    endtask

    task automatic step(input logic [7:0] r, input logic rd);
        exp_t e;
        int   p;
        bit   done;
        @(posedge clk);
        #1;
        req   = r;
        ready = rd;
        e.valid = (owner >= 0) && r[owner];
        e.sel   = 3'((owner >= 0) ? owner : last_sel);
        e.gnt   = (owner >= 0) ? (8'd1 << owner) : 8'd0;
        q.push_back(e);
        if (owner < 0) begin
            p = pick(r, mptr);
            if (p >= 0) begin
                owner = p; burst = 0; last_sel = p;
            end
        end else begin
            done = !r[owner];
            if (e.valid && rd) begin
                burst++;
                if (burst == H) done = 1;
            end
            if (done) begin
                mptr = (owner + 1) % N;
                p = pick(r, mptr);
                if (p >= 0) begin
                    owner = p; burst = 0; last_sel = p;
                end else begin
                    owner = -1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("gnt",   32'(gnt),   32'(e.gnt));
            check("sel",   32'(sel),   32'(e.sel));
            check("valid", 32'(valid), 32'(e.valid));
        end
    end

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt",   32'(gnt),   32'd0);
        check("reset_sel",   32'(sel),   32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;

        repeat (3) step(8'h00, 1'b1);
        repeat (3) step(8'h04, 1'b1);
        repeat (2) step(8'h00, 1'b1);

        for (int i = 0; i < 20; i++) step(8'h81, 1'b1);
        repeat (2) step(8'h00, 1'b1);

        for (int i = 0; i < 70; i++) step(8'hFF, 1'(i % 2));
        repeat (2) step(8'h00, 1'b1);

        step(8'h08, 1'b1);
        step(8'h28, 1'b1);
        step(8'h28, 1'b1);
        step(8'h20, 1'b1);
        repeat (3) step(8'h20, 1'b1);
        repeat (2) step(8'h00, 1'b1);

        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            step(r, 1'(($urandom % 4) != 0));
        end

        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        req   = 8'h00;
        #1;
        check("rst_mid_gnt",   32'(gnt),   32'd0);
        check("rst_mid_sel",   32'(sel),   32'd0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step(8'h02, 1'b1);

        for (int i = 0; i < 200; i++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            step(r, 1'(($urandom % 3) != 0));
        end

        @(negedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
